// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Two-phase master/slave: the next state is captured on ph2 and becomes visible on ph1.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  // acc_hi/acc_lo: {product high, multiplier shifting out} for multiply,
  // {partial remainder, dividend shifting out / quotient shifting in} for divide.
  typedef struct packed {
    state_t           st;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
  } regs_t;

  regs_t r_m;
  regs_t r_q;
  regs_t w_d;

  logic                 w_signed;
  logic                 w_sgn_diff;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_shift;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_sub;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_f;
  logic [WIDTH-1:0]     w_quo_f;
  logic [WIDTH-1:0]     w_rem_f;

  assign w_signed   = (op == OP_MULT) || (op == OP_DIV);
  assign w_sgn_diff = w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_a_mag    = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag    = (w_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add step: add multiplicand when the outgoing multiplier bit is set.
  assign w_mul_sum = {1'b0, r_q.acc_hi} + (r_q.acc_lo[0] ? {1'b0, r_q.opb} : '0);

  // Restoring step: the shifted remainder needs one extra bit; once it fits,
  // the difference is below the divisor so the low WIDTH bits are exact.
  assign w_shift = {r_q.acc_hi, r_q.acc_lo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_q.opb});
  assign w_sub   = w_shift[WIDTH-1:0] - r_q.opb;

  assign w_prod   = {r_q.acc_hi, r_q.acc_lo};
  assign w_prod_f = r_q.neg_q ? -w_prod : w_prod;
  assign w_quo_f  = r_q.neg_q ? -r_q.acc_lo : r_q.acc_lo;
  assign w_rem_f  = r_q.neg_r ? -r_q.acc_hi : r_q.acc_hi;

  always_comb begin
    w_d      = r_q;
    w_d.done = 1'b0;
    case (r_q.st)
      S_IDLE: begin
        if (start && !clear) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              w_d.st     = S_RUN;
              w_d.cnt    = CW'(WIDTH-1);
              w_d.is_div = 1'b0;
              w_d.neg_q  = w_sgn_diff;
              w_d.neg_r  = 1'b0;
              w_d.div0   = 1'b0;
              w_d.acc_hi = '0;
              w_d.acc_lo = w_b_mag;
              w_d.opb    = w_a_mag;
            end
            OP_DIV, OP_DIVU: begin
              w_d.st     = S_RUN;
              w_d.cnt    = CW'(WIDTH-1);
              w_d.is_div = 1'b1;
              w_d.neg_q  = w_sgn_diff;
              w_d.neg_r  = w_signed & a[WIDTH-1];
              w_d.div0   = (op == OP_DIV) && (b == '0);
              w_d.acc_hi = '0;
              w_d.acc_lo = w_a_mag;
              w_d.opb    = w_b_mag;
            end
            OP_MTHI: w_d.hi = a;
            OP_MTLO: w_d.lo = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (clear) begin
          w_d.st = S_IDLE;
        end else begin
          if (r_q.is_div) begin
            w_d.acc_hi = w_fits ? w_sub : w_shift[WIDTH-1:0];
            w_d.acc_lo = {r_q.acc_lo[WIDTH-2:0], w_fits};
          end else begin
            w_d.acc_hi = w_mul_sum[WIDTH:1];
            w_d.acc_lo = {w_mul_sum[0], r_q.acc_lo[WIDTH-1:1]};
          end
          w_d.cnt = r_q.cnt - CW'(1);
          if (r_q.cnt == '0) w_d.st = S_FIX;
        end
      end
      S_FIX: begin
        w_d.st = S_IDLE;
        if (!clear) begin
          w_d.done = 1'b1;
          if (r_q.is_div) begin
            // Divide by zero: the remainder already restores to raw a
            // (sign-corrected |a|); only the quotient needs forcing.
            w_d.lo = r_q.div0 ? '1 : w_quo_f;
            w_d.hi = w_rem_f;
          end else begin
            w_d.hi = w_prod_f[2*WIDTH-1:WIDTH];
            w_d.lo = w_prod_f[WIDTH-1:0];
          end
        end
      end
      default: w_d.st = S_IDLE;
    endcase
  end

  // All-zero is the reset image (S_IDLE encodes as 0).
  always_ff @(posedge ph2) begin
    if (reset) r_m <= '0;
    else       r_m <= w_d;
  end

  always_ff @(posedge ph1) begin
    r_q <= r_m;
  end

  assign busy = (r_q.st != S_IDLE);
  assign done = r_q.done;
  assign hi   = r_q.hi;
  assign lo   = r_q.lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core.
- Sits downstream of the execute-stage operand muxes and consumes the same forwarded srca/srcb values the ALU receives.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- Exposes busy so hazard logic can stall MFHI/MFLO and any further mul/div issue.

Parameters:
WIDTH  32  operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH

Ports:
ph1    input  1      clock phase 1; state and outputs update on ph1, as in the existing flops
ph2    input  1      clock phase 2; next state and inputs sampled on ph2
reset  input  1      synchronous, active-high reset
start  input  1      issue strobe; sampled only when busy=0
op     input  3      000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (ignored)
a      input  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO data)
b      input  WIDTH  rt operand (multiplier or divisor)
clear  input  1      abort an in-flight operation (branch flush or exception)
busy   output 1      operation in progress
done   output 1      one-cycle pulse when HI/LO take a mul/div result
hi     output WIDTH  HI register
lo     output WIDTH  LO register

Behaviour:
- Single clock domain: ph1/ph2 are the two non-overlapping phases of the one processor clock. The block uses the master/slave style of the existing flops: sample during ph2, update q during ph1.
- Reset is synchronous and active-high. It has priority over every other input.
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- FSM states:
  - IDLE
    - start=1 with a mul/div op: latch operand magnitudes (absolute values for signed ops; raw values for unsigned ops), latch sign flags, set counter=WIDTH-1, go to RUN.
    - start=1 with MTHI: hi<=a next cycle; MTLO: lo<=a next cycle. Stay IDLE; busy stays 0.
    - op=none or reserved: no action.
  - RUN
    - One radix-2 step per cycle.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract; the partial remainder needs WIDTH+1 bits.
    - Counter decrements each cycle. Counter=0 -> go to FIX.
  - FIX
    - Multiply: negate the full 2*WIDTH product if the operand signs differ.
    - Divide: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
    - Write hi/lo (hi=product[2W-1:W] or remainder; lo=product[W-1:0] or quotient), then go to IDLE.
- Timing:
  - Start is sampled in cycle 0.
  - busy=1 in cycles 1..WIDTH+1 (33 cycles when WIDTH=32).
  - hi/lo hold their new value, and done=1, in cycle WIDTH+2 only.
- Divide by zero:
  - DIVU follows the normal algorithm, which gives lo=all ones and hi=a.
  - DIV: FIX forces lo=all ones and hi=raw a.
  - Full latency in both cases; no exception is raised.
- Signed overflow (DIV 0x80000000 / -1): lo=0x80000000, hi=0. This falls out of the magnitude arithmetic with 32-bit wrap.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit is required to stall such instructions.
- clear:
  - clear=1 in RUN or FIX: the next state is IDLE and busy drops the next cycle.
  - hi/lo keep their prior values and done stays 0.
  - clear=1 in IDLE with start=1: the issue is suppressed.
- reset in RUN: return to IDLE, hi=lo=0.
- hi/lo change only on reset, MTHI/MTLO, or the FIX write.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 33 cycles; in cycle 34 done=1, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0xFFFFFFF9 b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
- MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, busy stays 0. MTLO issued while busy -> lo unchanged, and a later mul/div result is correct.
- With hi=0xAAAA0000 and lo=0x0000BBBB, start DIVU 100/7 and assert clear in cycle 10 -> busy=0 in cycle 11, done never pulses, hi/lo unchanged. A fresh DIVU 100/7 then gives lo=14, hi=2.
- Assert reset in cycle 5 of a MULT -> next cycle busy=0, hi=0, lo=0. A start in the same cycle as reset is ignored.
